// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DATA_BITS    = 8;
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial input plus byte-output handshake of the UART receiver.
// valid/ready: a byte transfers on a rising edge where valid && ready; valid is
// held with data stable until then, and ready is ignored while valid is low.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx, ready,
        input  data, valid, frame_err, overrun, busy
    );

    modport slave (
        input  rx, ready,
        output data, valid, frame_err, overrun, busy
    );

endinterface

// File: rtl/uart_rx_filter.sv
// Two-flop synchroniser followed by a 3-sample majority vote on the rx line.
// Everything presets to 1 so reset never looks like a start edge.
module uart_rx_filter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rxf_o,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] shift_q;
    logic       rxf_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            shift_q    <= 3'b111;
            rxf_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            shift_q    <= {shift_q[1:0], sync2_q};
            rxf_prev_q <= rxf_o;
        end
    end

    assign rxf_o  = (shift_q[0] & shift_q[1]) |
                    (shift_q[0] & shift_q[2]) |
                    (shift_q[1] & shift_q[2]);
    assign fall_o = rxf_prev_q & ~rxf_o;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: centre-of-bit sampling, false-start rejection, framing
// error and overrun pulses, byte delivered on a valid/ready handshake.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_rx_byte_if.slave  bus,
    output uart_state_e    dbg_state_o
);

    localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic rxf;
    logic fall;

    uart_rx_filter u_filter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rx_i   (bus.rx),
        .rxf_o  (rxf),
        .fall_o (fall)
    );

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);

            if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rxf) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxf;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (!rxf) begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!valid_q || bus.ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                end

                BREAK: begin
                    cnt_q <= '0;
                    if (rxf) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receive stage. Consumes the raw asynchronous `rx` pin of the UART top and produces 8N1 bytes on a valid/ready handshake for downstream logic (echo/FIFO/TX path).
- Includes synchronisation, mid-bit majority sampling, false-start rejection, framing-error detection and overrun reporting.
- Target: 50 MHz clock, 115200 baud, LSB-first, 1 start bit, 8 data bits, 1 stop bit, no parity.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BIT_CYCLES, CLK_FREQ/BAUD (434), clocks per bit, integer-truncated. Derived; must not be overridden.
- HALF_CYCLES, BIT_CYCLES/2 (217), start-bit centre offset. Derived.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available; held until accepted.
- ready  input  1  consumer accepts the byte when valid&&ready at a rising edge.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  one-cycle pulse when a byte completes while the previous byte is still unaccepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - Outputs: data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Internal: state=IDLE, counters=0, synchroniser and filter preset to 1.
- Input conditioning:
  - rx passes through a 2-flop synchroniser into a 3-bit shift register.
  - The filtered bit `rxf` is the majority of those 3 bits.
  - Total conditioning delay is 3–4 cycles.
- IDLE:
  - rxf falling (1→0) → START. Clear the cycle counter.
- START:
  - At count HALF_CYCLES-1, sample rxf.
  - rxf=1 → false start; return to IDLE with no outputs.
  - rxf=0 → DATA, bit index=0, counter restarts.
- DATA:
  - Every BIT_CYCLES, sample rxf into shift[idx], LSB first.
  - After idx=7 → STOP.
- STOP:
  - At BIT_CYCLES, sample rxf.
  - rxf=1 and valid=0, or rxf=1 and valid&&ready in the same cycle:
    - load data, set valid=1 on the next edge;
    - go to IDLE immediately (mid-stop), so a start edge that follows back-to-back is caught.
  - rxf=1, valid=1, ready=0:
    - new byte dropped; old data kept; overrun pulses 1 cycle;
    - go to IDLE.
  - rxf=0:
    - frame_err pulses 1 cycle; byte discarded;
    - go to BREAK.
- BREAK:
  - Wait until rxf=1, then IDLE. A long low (break) yields exactly one frame_err.
- Handshake:
  - valid clears on the edge where valid&&ready.
  - ready is ignored while valid=0.
  - data never changes while valid=1.
- Latency:
  - valid rises between 9.5·BIT_CYCLES+3 and 9.5·BIT_CYCLES+6 cycles after the rx falling edge at the pin.
  - That is about 4126–4129 cycles at the defaults.
- Counters:
  - Bit counter is $clog2(BIT_CYCLES) bits wide, saturation-free, cleared on every state entry.
  - Bit index is 3 bits.
- Baud tolerance: sampling must remain correct for a sender with ±2% baud error.

Decomposition:
- Package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - constants DATA_BITS=8, default CLK_FREQ and BAUD;
  - function bit_cycles(clk, baud).
- Sub-module `uart_rx_filter`: 2-flop synchroniser plus 3-sample majority. Ports: clk, rst, rx → rxf, fall.

Test Plan:
1. Reset, idle line. Send "A" (0x41) at a period of 8680 ns with ready held 1 → one valid pulse with data=0x41; frame_err=0, overrun=0.
2. 26 back-to-back bytes "A".."Z", no idle gap, ready=1 → 26 valid handshakes in order 0x41..0x5A, none lost.
3. ready=0. Send 0x55 then 0xAA → data=0x55 held, valid=1, one overrun pulse after the second stop bit. Then raise ready → valid drops and data is still 0x55.
4. Send 0x41 with stop bit forced 0, then hold rx low for 3 bit times → exactly one frame_err pulse, no valid; next "B" → data=0x42.
5. 2 µs low glitch on idle rx → false start rejected: no valid, no frame_err, busy returns to 0 within 1 bit time.
6. Assert rst low mid-DATA of a byte, release, then send 0x5A → all outputs 0 during reset; the partial byte produces nothing; data=0x5A received. Repeat cases 1–2 with the sender at 115200·1.02 and ·0.98 → identical results.
